// File: rtl/except_ctrl_pkg.sv
// Shared CPU definitions: exception codes, the CP0 exception request record,
// the sequencer state encoding and CP0 status/cause field positions.
package cpu_defs;

  localparam logic [4:0] EXCCODE_INT  = 5'h00;
  localparam logic [4:0] EXCCODE_ADEL = 5'h04;
  localparam logic [4:0] EXCCODE_ADES = 5'h05;
  localparam logic [4:0] EXCCODE_SYS  = 5'h08;
  localparam logic [4:0] EXCCODE_BP   = 5'h09;
  localparam logic [4:0] EXCCODE_RI   = 5'h0A;
  localparam logic [4:0] EXCCODE_OV   = 5'h0C;

  // Bit positions inside the MEM-stage exception flag vector.
  localparam int MEM_EXC_ADEL_IF = 0;
  localparam int MEM_EXC_SYS     = 1;
  localparam int MEM_EXC_BRK     = 2;
  localparam int MEM_EXC_RI      = 3;
  localparam int MEM_EXC_OV      = 4;
  localparam int MEM_EXC_ADES_D  = 5;
  localparam int MEM_EXC_ADEL_D  = 6;
  localparam int MEM_EXC_ERET    = 7;

  localparam int STATUS_IE     = 0;
  localparam int STATUS_EXL    = 1;
  localparam int STATUS_ERL    = 2;
  localparam int STATUS_IM_LSB = 8;
  localparam int STATUS_BEV    = 22;
  localparam int CAUSE_IP_LSB  = 8;

  typedef struct packed {
    logic        flush;
    logic        eret;
    logic [4:0]  code;
    logic [31:0] cur_pc;
    logic        delayslot;
    logic [31:0] extra;
  } ExceptReq_t;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    REDIRECT
  } ExcCtrlState_t;

endpackage

// File: rtl/except_ctrl_int_sync.sv
// N-bit multi-flop synchroniser for asynchronous level inputs; STAGES must be
// at least 2. Bit 0 of the stage array is the flop nearest the input.
module int_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [STAGES-1:0][WIDTH-1:0] r_sync;

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the previous value of its neighbour on the same edge.
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[STAGES-2:0], i_async};
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/except_ctrl.sv
// Exception/interrupt sequencer: prioritises MEM-stage exceptions and pending
// interrupts, issues the one-cycle CP0 request, flushes, then redirects fetch.
module except_ctrl
  import cpu_defs::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] VEC_BOOT    = 32'hBFC0_0380,
  parameter logic [31:0] VEC_NORMAL  = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  ext_int,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_delayslot,
  input  logic [7:0]  mem_exc,
  input  logic [31:0] mem_badaddr,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  input  logic [31:0] cp0_count,
  input  logic [31:0] cp0_compare,
  input  logic        compare_we,
  output logic [5:0]  int_req,
  output ExceptReq_t  except_req,
  output logic        flush_pipe,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  logic [5:0]    w_sync;
  logic          r_timer_pend;
  ExcCtrlState_t r_state, w_next;
  logic [31:0]   r_target;

  logic [7:0]    w_ip, w_im;
  logic          w_int_take, w_trigger;
  logic          w_eret;
  logic [4:0]    w_code;
  logic [31:0]   w_extra, w_target;

  int_sync #(.WIDTH(6), .STAGES(SYNC_STAGES)) u_int_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (ext_int),
    .o_sync  (w_sync)
  );

  // A compare write in the same cycle as a match must leave the timer clear.
  always_ff @(posedge clk) begin
    if (rst)                            r_timer_pend <= 1'b0;
    else if (compare_we)                r_timer_pend <= 1'b0;
    else if (cp0_count == cp0_compare)  r_timer_pend <= 1'b1;
  end

  assign int_req = {w_sync[5] | r_timer_pend, w_sync[4:0]};

  assign w_ip       = cp0_cause[CAUSE_IP_LSB +: 8];
  assign w_im       = cp0_status[STATUS_IM_LSB +: 8];
  assign w_int_take = cp0_status[STATUS_IE] & ~cp0_status[STATUS_EXL] &
                      ~cp0_status[STATUS_ERL] & (|(w_ip & w_im)) & mem_valid;
  assign w_trigger  = mem_valid & (w_int_take | (|mem_exc));

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_code  = EXCCODE_INT;
    w_extra = '0;
    w_eret  = 1'b0;
    if (w_int_take)                      w_code = EXCCODE_INT;
    else if (mem_exc[MEM_EXC_ADEL_IF]) begin
      w_code  = EXCCODE_ADEL;
      w_extra = mem_pc;
    end
    else if (mem_exc[MEM_EXC_RI])        w_code = EXCCODE_RI;
    else if (mem_exc[MEM_EXC_SYS])       w_code = EXCCODE_SYS;
    else if (mem_exc[MEM_EXC_BRK])       w_code = EXCCODE_BP;
    else if (mem_exc[MEM_EXC_OV])        w_code = EXCCODE_OV;
    else if (mem_exc[MEM_EXC_ADEL_D]) begin
      w_code  = EXCCODE_ADEL;
      w_extra = mem_badaddr;
    end
    else if (mem_exc[MEM_EXC_ADES_D]) begin
      w_code  = EXCCODE_ADES;
      w_extra = mem_badaddr;
    end
    else if (mem_exc[MEM_EXC_ERET])      w_eret = 1'b1;
  end

  assign w_target = w_eret                 ? cp0_epc  :
                    cp0_status[STATUS_BEV] ? VEC_BOOT : VEC_NORMAL;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_target <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_trigger) r_target <= w_target;
    end
  end

  always_comb begin
    w_next         = r_state;
    except_req     = '0;
    flush_pipe     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    busy           = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_trigger) begin
          except_req = '{flush: 1'b1, eret: w_eret, code: w_code, cur_pc: mem_pc,
                         delayslot: mem_delayslot, extra: w_extra};
          flush_pipe = 1'b1;
          busy       = 1'b1;
          w_next     = FLUSH;
        end
      end
      FLUSH: begin
        flush_pipe = 1'b1;
        busy       = 1'b1;
        w_next     = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = r_target;
        busy           = 1'b1;
        w_next         = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // Reset silences the sequencer immediately, so an aborted sequence never redirects.
    if (rst) begin
      except_req     = '0;
      flush_pipe     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      busy           = 1'b0;
    end
  end

  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, cp0_status[31:23], cp0_status[21:16], cp0_status[7:3],
                         cp0_cause[31:16], cp0_cause[7:0]};

endmodule

// File: tb/tb_except_ctrl.sv
// Scoreboard bench for except_ctrl: stimulus queues the expected CP0 request
// and redirect target; a negedge monitor pops and compares when they appear.
module tb_except_ctrl;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  ext_int;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_delayslot;
  logic [7:0]  mem_exc;
  logic [31:0] mem_badaddr;
  logic [31:0] cp0_status, cp0_cause, cp0_epc, cp0_count, cp0_compare;
  logic        compare_we;
  logic [5:0]  int_req;
  ExceptReq_t  except_req;
  logic        flush_pipe, redirect_valid, busy;
  logic [31:0] redirect_pc;

  except_ctrl dut (
    .clk(clk), .rst(rst), .ext_int(ext_int), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .mem_delayslot(mem_delayslot), .mem_exc(mem_exc), .mem_badaddr(mem_badaddr),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
    .cp0_count(cp0_count), .cp0_compare(cp0_compare), .compare_we(compare_we),
    .int_req(int_req), .except_req(except_req), .flush_pipe(flush_pipe),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        eret;
    logic [4:0]  code;
    logic [31:0] cur_pc;
    logic        delayslot;
    logic [31:0] extra;
  } exp_exc_t;

  exp_exc_t    exc_q[$];
  logic [31:0] redir_q[$];
  exp_exc_t    mon_exc;
  logic [31:0] mon_pc;
  int n_checks = 0;
  int n_errors = 0;
  int cycle = 0;
  int last_flush_cycle = -100;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes one expected entry per observed request or redirect.
  always @(negedge clk) begin
    if (except_req.flush === 1'b1) begin
      if (exc_q.size() == 0) check("unexpected_flush", 1, 0);
      else begin
        mon_exc = exc_q.pop_front();
        check("req_eret",      except_req.eret,      mon_exc.eret);
        check("req_code",      except_req.code,      mon_exc.code);
        check("req_cur_pc",    except_req.cur_pc,    mon_exc.cur_pc);
        check("req_delayslot", except_req.delayslot, mon_exc.delayslot);
        check("req_extra",     except_req.extra,     mon_exc.extra);
      end
      last_flush_cycle = cycle;
    end
    if (redirect_valid === 1'b1) begin
      if (redir_q.size() == 0) check("unexpected_redirect", 1, 0);
      else begin
        mon_pc = redir_q.pop_front();
        check("redirect_pc", redirect_pc, mon_pc);
        check("redirect_latency", cycle - last_flush_cycle, 2);
      end
    end
  end

  task automatic idle_mem();
    mem_valid = 1'b0; mem_exc = '0; mem_pc = '0; mem_delayslot = 1'b0; mem_badaddr = '0;
  endtask

  // One exception in cycle N, junk on mem_* during FLUSH, optional reset there.
  task automatic issue(input logic [7:0] exc, input logic [31:0] pc, input logic ds,
                       input logic [31:0] bad, input logic [4:0] code, input logic eret,
                       input logic [31:0] extra, input logic [31:0] target,
                       input bit reset_in_flush);
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_exc = exc; mem_pc = pc; mem_delayslot = ds; mem_badaddr = bad;
    exc_q.push_back('{eret: eret, code: code, cur_pc: pc, delayslot: ds, extra: extra});
    if (!reset_in_flush) redir_q.push_back(target);
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_exc = 8'h02; mem_pc = 32'hDEAD_0000;
    check("flush_state_flush_pipe", flush_pipe, 1);
    check("flush_state_busy", busy, 1);
    check("flush_state_req", except_req.flush, 0);
    if (reset_in_flush) begin
      rst = 1'b1;
      idle_mem();
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_flush_pipe", flush_pipe, 0);
      check("rst_busy", busy, 0);
      check("rst_redirect_valid", redirect_valid, 0);
      check("rst_except_req", except_req, '0);
      @(posedge clk); #1;
      check("rst_no_redirect_later", redirect_valid, 0);
    end else begin
      idle_mem();
      @(posedge clk); #1;
      check("redirect_state_flush_pipe", flush_pipe, 0);
      check("redirect_state_busy", busy, 1);
      @(posedge clk); #1;
      check("idle_after_busy", busy, 0);
    end
  endtask

  initial begin
    rst = 1'b1; ext_int = 6'h3F; compare_we = 1'b0;
    cp0_status = '0; cp0_cause = '0; cp0_epc = '0;
    cp0_count = '0; cp0_compare = 32'h10;
    idle_mem();
    repeat (2) @(posedge clk);
    #1;
    check("reset_int_req", int_req, 0);
    check("reset_except_req", except_req, '0);
    check("reset_flush_pipe", flush_pipe, 0);
    check("reset_redirect", {redirect_valid, redirect_pc}, 0);
    check("reset_busy", busy, 0);
    ext_int = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Syscall, bev=1.
    cp0_status = 32'h0040_0000;
    issue(8'h02, 32'hBFC0_0100, 1'b0, 32'h0, 5'h08, 1'b0, 32'h0, 32'hBFC0_0380, 1'b0);
    // Data AdEL in a delay slot, bev=0.
    cp0_status = 32'h0;
    issue(8'h40, 32'h8000_1004, 1'b1, 32'h3, 5'h04, 1'b0, 32'h3, 32'h8000_0180, 1'b0);
    // ri+ov with HW2 pending: ie=0, then exl=1 masks, then ie=1 takes the interrupt.
    cp0_cause = 32'h0000_1000;
    issue(8'h18, 32'h8000_2000, 1'b0, 32'h0, 5'h0A, 1'b0, 32'h0, 32'h8000_0180, 1'b0);
    cp0_status = 32'h0000_1003;
    issue(8'h18, 32'h8000_2004, 1'b0, 32'h0, 5'h0A, 1'b0, 32'h0, 32'h8000_0180, 1'b0);
    cp0_status = 32'h0000_1001;
    issue(8'h18, 32'h8000_2008, 1'b0, 32'h0, 5'h00, 1'b0, 32'h0, 32'h8000_0180, 1'b0);
    cp0_status = 32'h0; cp0_cause = 32'h0;
    // ERET alone, then ERET with ov.
    cp0_epc = 32'h8000_2000;
    issue(8'h80, 32'h8000_3000, 1'b0, 32'h0, 5'h00, 1'b1, 32'h0, 32'h8000_2000, 1'b0);
    issue(8'h90, 32'h8000_3004, 1'b0, 32'h0, 5'h0C, 1'b0, 32'h0, 32'h8000_0180, 1'b0);
    // adel_if beats sys; ades_d alone; brk beats ov.
    issue(8'h03, 32'h8000_0003, 1'b0, 32'h0, 5'h04, 1'b0, 32'h8000_0003, 32'h8000_0180, 1'b0);
    issue(8'h20, 32'h8000_4000, 1'b0, 32'h1001, 5'h05, 1'b0, 32'h1001, 32'h8000_0180, 1'b0);
    issue(8'h14, 32'h8000_5000, 1'b0, 32'h0, 5'h09, 1'b0, 32'h0, 32'h8000_0180, 1'b0);

    // Flags without mem_valid are ignored.
    @(posedge clk); #1;
    mem_exc = 8'h7F; mem_pc = 32'h8000_6000; cp0_status = 32'h0000_FF01; cp0_cause = 32'h0000_FF00;
    #3;
    check("no_valid_flush", flush_pipe, 0);
    check("no_valid_busy", busy, 0);
    @(posedge clk); #1;
    idle_mem(); cp0_status = 32'h0; cp0_cause = 32'h0;

    // Reset asserted during FLUSH.
    issue(8'h02, 32'h8000_7000, 1'b0, 32'h0, 5'h08, 1'b0, 32'h0, 32'h8000_0180, 1'b1);

    // Timer: match, then compare write, then simultaneous match and write.
    @(posedge clk); #1;
    cp0_count = 32'h10;
    check("timer_before_match", int_req[5], 0);
    @(posedge clk); #1;
    cp0_count = 32'h11;
    check("timer_set", int_req[5], 1);
    compare_we = 1'b1;
    @(posedge clk); #1;
    compare_we = 1'b0;
    check("timer_cleared", int_req[5], 0);
    cp0_count = 32'h10; compare_we = 1'b1;
    @(posedge clk); #1;
    cp0_count = 32'h11; compare_we = 1'b0;
    check("timer_clear_wins", int_req[5], 0);
    @(posedge clk); #1;
    check("timer_stays_clear", int_req[5], 0);

    // ext_int[0] through the two-flop synchroniser.
    ext_int = 6'h01;
    @(posedge clk); #1;
    check("sync_rise_1cyc", int_req[0], 0);
    @(posedge clk); #1;
    check("sync_rise_2cyc", int_req, 6'h01);
    ext_int = 6'h00;
    @(posedge clk); #1;
    check("sync_fall_1cyc", int_req[0], 1);
    @(posedge clk); #1;
    check("sync_fall_2cyc", int_req[0], 0);

    repeat (3) @(posedge clk);
    #1;
    check("exc_q_drained", exc_q.size(), 0);
    check("redir_q_drained", redir_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
